// File: rtl/fp_mult_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_mult_pkg : shared state encoding and default sizing for the multiplier
//               issue controller.  Rev 1.0
// ----------------------------------------------------------------------------
package fp_mult_pkg;

  localparam int DEF_N       = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/operand_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// operand_fifo : operand-pair FIFO with extra-MSB pointers, no bypass.
//                Rev 1.0
// ----------------------------------------------------------------------------
module operand_fifo
  import fp_mult_pkg::*;
#(
  parameter int W     = 2 * DEF_N,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Full when the index bits match but the wrap bits differ.
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  assign head_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_mult_issue_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fp_mult_issue_ctrl : buffers operand pairs, issues one at a time to the
//                      multiplier, watchdogs it and holds the result. Rev 1.0
// ----------------------------------------------------------------------------
module fp_mult_issue_ctrl
  import fp_mult_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] mul_a,
  output logic [N-1:0] mul_b,
  output logic         mul_start,
  input  logic         mul_done,
  input  logic [N-1:0] mul_result,
  input  logic         mul_ovf,
  input  logic         mul_exc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_ovf,
  output logic         out_exc,
  output logic         out_timeout,
  output logic         busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  logic           fifo_full, fifo_empty, fifo_pop;
  logic [2*N-1:0] fifo_head;

  state_e         state_q, state_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [N-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [N-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d, exc_q, exc_d, to_q, to_d, oval_q, oval_d;

  operand_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid),
    .data_i  ({in_a, in_b}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    wdog_d   = wdog_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    exc_d    = exc_q;
    to_d     = to_q;
    oval_d   = oval_q;
    fifo_pop = 1'b0;

    if (oval_q && out_ready) begin
      oval_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        // A held result blocks the next issue so nothing is ever overwritten.
        if (!fifo_empty && !oval_q) begin
          fifo_pop = 1'b1;
          mul_a_d  = fifo_head[2*N-1:N];
          mul_b_d  = fifo_head[N-1:0];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        if (mul_done) begin
          res_d   = mul_result;
          ovf_d   = mul_ovf;
          exc_d   = mul_exc;
          to_d    = 1'b0;
          oval_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          exc_d   = 1'b0;
          to_d    = 1'b1;
          oval_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wdog_q  <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      exc_q   <= 1'b0;
      to_q    <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      exc_q   <= exc_d;
      to_q    <= to_d;
      oval_q  <= oval_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign mul_start   = (state_q == ST_ISSUE);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_valid   = oval_q;
  assign out_result  = res_q;
  assign out_ovf     = ovf_q;
  assign out_exc     = exc_q;
  assign out_timeout = to_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_issue_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fp_mult_issue_ctrl : randomized and directed bench with a cycle-timing
//                         reference model and a stand-in multiplier. Rev 1.0
// ----------------------------------------------------------------------------
module tb_fp_mult_issue_ctrl;

  localparam int N       = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
  localparam logic [31:0] INF = 32'h7F80_0000;

  logic         clk, reset, in_valid, in_ready;
  logic [N-1:0] in_a, in_b, mul_a, mul_b, mul_result, out_result;
  logic         mul_start, mul_done, mul_ovf, mul_exc;
  logic         out_valid, out_ready, out_ovf, out_exc, out_timeout, busy;

  fp_mult_issue_ctrl #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_done(mul_done), .mul_result(mul_result),
    .mul_ovf(mul_ovf), .mul_exc(mul_exc), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf),
    .out_exc(out_exc), .out_timeout(out_timeout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in multiplier arithmetic: 2.0 x 3.0 is exact, infinity propagates.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (a == INF || b == INF) return INF;
    return (a ^ {b[15:0], b[31:16]}) + 32'h0000_1234;
  endfunction
  function automatic logic fexc(input logic [31:0] a, input logic [31:0] b);
    return (a == INF) || (b == INF);
  endfunction
  function automatic logic fovf(input logic [31:0] a, input logic [31:0] b);
    return a[30] & b[30];
  endfunction

  // Multiplier responder; lat_cfg == 0 means it never answers.
  int          lat_cfg = 5;
  int          done_at = -1;
  logic [31:0] pend_res;
  logic        pend_ovf, pend_exc;

  initial begin
    mul_done = 1'b0; mul_result = '0; mul_ovf = 1'b0; mul_exc = 1'b0;
    forever begin
      @(posedge clk); #2;
      mul_done = 1'b0;
      if (done_at == cyc) begin
        mul_done = 1'b1; mul_result = pend_res; mul_ovf = pend_ovf; mul_exc = pend_exc;
        done_at = -1;
      end
      if (mul_start === 1'b1 && !reset) begin
        done_at  = (lat_cfg > 0) ? cyc + lat_cfg : -1;
        pend_res = fmul(mul_a, mul_b);
        pend_ovf = fovf(mul_a, mul_b);
        pend_exc = fexc(mul_a, mul_b);
      end
    end
  end

  int rdy_mode = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: FIFO as a queue, one op in flight, timing by cycle counts.
  logic [63:0] mq[$];
  bit          m_start, m_wait, m_active, m_ov, m_to, m_ovf, m_exc;
  logic [31:0] m_ma, m_mb, m_res;
  int          m_w, m_lat;

  function automatic void model_reset();
    mq.delete();
    m_start = 0; m_wait = 0; m_active = 0; m_ov = 0; m_to = 0; m_ovf = 0; m_exc = 0;
    m_ma = '0; m_mb = '0; m_res = '0; m_w = 0; m_lat = 0;
  endfunction

  function automatic void finish_op(input bit to);
    m_wait = 0; m_active = 0; m_ov = 1; m_to = to;
    m_res = to ? 32'h0 : fmul(m_ma, m_mb);
    m_ovf = to ? 1'b0 : fovf(m_ma, m_mb);
    m_exc = to ? 1'b0 : fexc(m_ma, m_mb);
  endfunction

  function automatic void model_step();
    bit          push, dec;
    logic [63:0] p;
    push = (in_valid === 1'b1) && (mq.size() < DEPTH);
    dec  = !m_active && (mq.size() != 0) && !m_ov;
    if (m_ov && out_ready === 1'b1) m_ov = 0;
    if (m_start) begin
      m_start = 0; m_wait = 1; m_w = 0;
    end else if (m_wait) begin
      if (m_lat > 0 && m_w == m_lat - 1) finish_op(1'b0);
      else if (m_w == TIMEOUT - 1)       finish_op(1'b1);
      else                               m_w++;
    end
    if (dec) begin
      p = mq.pop_front();
      m_ma = p[63:32]; m_mb = p[31:0];
      m_start = 1; m_active = 1; m_lat = lat_cfg;
    end
    if (push) mq.push_back({in_a, in_b});
  endfunction

  int nstarts = 0;
  int last_start = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) model_reset();
      else       model_step();
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("busy", busy, m_active || (mq.size() != 0));
      chk("mul_start", mul_start, m_start);
      if (m_start || m_wait) begin
        chk("mul_a", mul_a, m_ma);
        chk("mul_b", mul_b, m_mb);
      end
      chk("out_valid", out_valid, m_ov);
      if (m_ov || reset) begin
        chk("out_result", out_result, m_res);
        chk("out_ovf", out_ovf, m_ovf);
        chk("out_exc", out_exc, m_exc);
        chk("out_timeout", out_timeout, m_to);
      end
      if (mul_start === 1'b1) begin
        nstarts++;
        last_start = cyc;
      end
    end
  end

  int   nres = 0;
  logic res_exc[$];
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
        nres++;
        res_exc.push_back(out_exc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bit acc;
    in_valid = 1'b1; in_a = a; in_b = b;
    do begin
      acc = (in_ready === 1'b1);
      tick();
      n++;
    end while (!acc && n < 300);
    chk("push_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (mul_start !== 1'b1 && n < 100) begin tick(); n++; end
    chk("wait_start", mul_start, 1);
  endtask

  task automatic wait_out();
    int n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    chk("wait_out", out_valid, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || out_valid !== 1'b0) && n < budget) begin tick(); n++; end
    chk("drain", {busy, out_valid}, 0);
  endtask

  logic [31:0] a3[5], b3[5];
  int t0, nres0, starts0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_out_result", out_result, 0);
    reset = 1'b0;
    rdy_mode = 1;
    tick();

    // Single op: 2.0 x 3.0, multiplier latency 33.
    lat_cfg = 33;
    t0 = cyc;
    push_pair(32'h4000_0000, 32'h4040_0000);
    wait_start();
    chk("t2_start_lat", cyc - t0, 2);
    wait_out();
    chk("t2_out_lat", cyc - last_start, 34);
    chk("t2_result", out_result, 32'h40C0_0000);
    chk("t2_timeout", out_timeout, 0);
    wait_idle(50);

    // Reset while the multiplier is working; its late done must be ignored.
    lat_cfg = 20;
    push_pair($urandom, $urandom);
    wait_start();
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_mul_start", mul_start, 0);
    chk("t1_busy", busy, 0);
    chk("t1_mul_a", mul_a, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (25) tick();
    chk("t1_late_done_ignored", out_valid, 0);

    // Five pairs with the consumer stalled.
    rdy_mode = 0; lat_cfg = 5;
    tick();
    nres0 = nres; starts0 = nstarts;
    for (int i = 0; i < 5; i++) begin
      a3[i] = $urandom; b3[i] = $urandom;
      push_pair(a3[i], b3[i]);
    end
    repeat (15) tick();
    chk("t3_in_ready_full", in_ready, 0);
    chk("t3_one_start", nstarts - starts0, 1);
    chk("t3_held_valid", out_valid, 1);
    chk("t3_held_result", out_result, fmul(a3[0], b3[0]));
    repeat (5) tick();
    chk("t3_still_held", out_result, fmul(a3[0], b3[0]));
    chk("t3_no_second_start", nstarts - starts0, 1);
    rdy_mode = 1;
    wait_idle(400);
    chk("t3_count", nres - nres0, 5);

    // Eight-op stream; only the third carries an infinity operand.
    lat_cfg = 6;
    nres0 = nres;
    for (int i = 0; i < 8; i++) begin
      push_pair((i == 2) ? INF : ($urandom & 32'h3FFF_FFFF), $urandom & 32'h3FFF_FFFF);
    end
    wait_idle(600);
    chk("t4_count", nres - nres0, 8);
    for (int i = 0; i < 8; i++) begin
      if (nres0 + i < res_exc.size()) chk("t4_exc", res_exc[nres0 + i], (i == 2));
      else                            chk("t4_missing", nres0 + i, res_exc.size());
    end

    // Hung multiplier, then a normal op.
    lat_cfg = 0;
    push_pair($urandom, $urandom);
    wait_out();
    chk("t5_timeout", out_timeout, 1);
    chk("t5_result", out_result, 0);
    chk("t5_ovf", out_ovf, 0);
    chk("t5_lat", cyc - last_start, TIMEOUT + 1);
    tick();
    lat_cfg = 7;
    a3[0] = $urandom; b3[0] = $urandom;
    push_pair(a3[0], b3[0]);
    wait_out();
    chk("t5_next_timeout", out_timeout, 0);
    chk("t5_next_result", out_result, fmul(a3[0], b3[0]));
    wait_idle(50);

    // Consumer toggling every cycle.
    rdy_mode = 2; lat_cfg = 3;
    nres0 = nres;
    for (int i = 0; i < 6; i++) push_pair($urandom, $urandom);
    wait_idle(400);
    chk("t6_count", nres - nres0, 6);

    // Random traffic segments.
    rdy_mode = 3;
    for (int s = 0; s < 3; s++) begin
      lat_cfg = $urandom_range(1, 12);
      repeat (40) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = $urandom; in_b = $urandom;
        tick();
      end
      in_valid = 1'b0;
      wait_idle(1000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
